stream_mux: RTL and testbench

Parametrised, registered N-channel, W-bit stream multiplexer with valid/ready handshakes. It selects one of CHANNELS input streams, either by an explicit select or by round-robin arbitration, and registers the winning word into a single output stage. It sits between datapath producers (ALU, load unit, immediate path) and a shared consumer such as a register-file write port or bus, and replaces fixed-width, purely combinational mux trees where back-pressure is needed.

---
 rtl/stream_mux.sv | 128 ++++++++++++
 tb/tb_stream_mux.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/stream_mux.sv
// stream_mux: registered N-channel, W-bit stream multiplexer with
// valid/ready handshakes on every input and on the single output.
//
// A channel is picked either by an explicit select (mode = 0) or by a
// round-robin scan starting at an internal pointer (mode = 1). The winning
// word is captured into one output register. That register can drain and
// reload in the same cycle, so the block sustains one word per cycle.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_data    CHANNELS*WIDTH, channel i in bits [i*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel ready, combinational, at most one bit high
//   mode       0 = fixed select, 1 = round-robin
//   sel        channel index used in fixed-select mode
//   out_data   registered output word
//   out_chan   channel index that produced out_data
//   out_valid  output register holds a word
//   out_ready  consumer accepts out_data this cycle
module stream_mux #(
   parameter int WIDTH    = 16,
   parameter int CHANNELS = 4,
   parameter int SELW     = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   input  logic [CHANNELS-1:0]       in_valid,
   output logic [CHANNELS-1:0]       in_ready,
   input  logic                      mode,
   input  logic [SELW-1:0]           sel,
   output logic [WIDTH-1:0]          out_data,
   output logic [SELW-1:0]           out_chan,
   output logic                      out_valid,
   input  logic                      out_ready
);

   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [SELW-1:0]  out_chan_q, out_chan_d;
   logic             out_valid_q, out_valid_d;
   logic [SELW-1:0]  ptr_q, ptr_d;

   logic             accept;
   logic             gvalid;
   logic             xfer;
   logic [SELW-1:0]  grant;
   logic [WIDTH-1:0] grant_data;

   // The register can take a new word when it is empty or is being drained.
   assign accept = !out_valid_q || out_ready;

   // Grant selection. In fixed mode an out-of-range sel matches no channel,
   // so gvalid stays low and that channel can never be granted.
   // In round-robin mode the scan runs from the farthest offset down to
   // offset 0. The last match written therefore belongs to the channel
   // closest to ptr.
   always_comb begin
      grant  = '0;
      gvalid = 1'b0;
      if (!mode) begin
         grant = sel;
         for (int i = 0; i < CHANNELS; i++) begin
            if (sel == SELW'(i)) gvalid = in_valid[i];
         end
      end else begin
         gvalid = |in_valid;
         for (int k = CHANNELS - 1; k >= 0; k--) begin
            for (int i = 0; i < CHANNELS; i++) begin
               if (((int'(ptr_q) + k) % CHANNELS) == i && in_valid[i])
                  grant = SELW'(i);
            end
         end
      end
   end

   // rst gates the handshake so that nothing is accepted during reset.
   assign xfer = accept && gvalid && !rst;

   generate
      for (genvar g = 0; g < CHANNELS; g++) begin : g_rdy
         assign in_ready[g] = xfer && (grant == SELW'(g));
      end
   endgenerate

   always_comb begin
      grant_data = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (grant == SELW'(i)) grant_data = in_data[i*WIDTH +: WIDTH];
      end
   end

   always_comb begin
      out_data_d  = out_data_q;
      out_chan_d  = out_chan_q;
      out_valid_d = out_valid_q;
      ptr_d       = ptr_q;
      if (xfer) begin
         // Covers a load into an empty register and a same-cycle drain+reload.
         out_data_d  = grant_data;
         out_chan_d  = grant;
         out_valid_d = 1'b1;
         ptr_d       = (grant == SELW'(CHANNELS - 1)) ? '0 : grant + SELW'(1);
      end else if (out_valid_q && out_ready) begin
         // Drain with nothing to refill: data and chan keep their last values.
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_data_q  <= '0;
         out_chan_q  <= '0;
         out_valid_q <= 1'b0;
         ptr_q       <= '0;
      end else begin
         out_data_q  <= out_data_d;
         out_chan_q  <= out_chan_d;
         out_valid_q <= out_valid_d;
         ptr_q       <= ptr_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_chan  = out_chan_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_stream_mux.sv
// Testbench for stream_mux. It drives a 4-channel build and a 3-channel build
// from shared stimulus and checks both every cycle against a behavioural
// reference model. Directed scenarios also carry fixed expected values.
module tb_stream_mux;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] in_data;
   logic [3:0]  in_valid;
   logic        mode;
   logic [1:0]  sel;
   logic        out_ready;

   logic [3:0]  in_ready4;
   logic [15:0] out_data4;
   logic [1:0]  out_chan4;
   logic        out_valid4;

   logic [2:0]  in_ready3;
   logic [15:0] out_data3;
   logic [1:0]  out_chan3;
   logic        out_valid3;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference state per build: index 0 = 4 channels, index 1 = 3 channels.
   logic        m_vld [2];
   logic [15:0] m_dat [2];
   int          m_chn [2];
   int          m_ptr [2];

   always #5 clk = ~clk;

   stream_mux #(.WIDTH(16), .CHANNELS(4), .SELW(2)) dut4 (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready4), .mode(mode), .sel(sel), .out_data(out_data4),
      .out_chan(out_chan4), .out_valid(out_valid4), .out_ready(out_ready));

   stream_mux #(.WIDTH(16), .CHANNELS(3), .SELW(2)) dut3 (
      .clk(clk), .rst(rst), .in_data(in_data[47:0]), .in_valid(in_valid[2:0]),
      .in_ready(in_ready3), .mode(mode), .sel(sel), .out_data(out_data3),
      .out_chan(out_chan3), .out_valid(out_valid3), .out_ready(out_ready));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Grant the model derives from the rules. It returns -1 when nothing can
   // be granted.
   function automatic int model_grant(int n, int p);
      if (!mode) return (int'(sel) < n && in_valid[sel]) ? int'(sel) : -1;
      for (int k = 0; k < n; k++)
         if (in_valid[(p + k) % n]) return (p + k) % n;
      return -1;
   endfunction

   task automatic set_word(input int i, input logic [15:0] v);
      in_data[i*16 +: 16] = v;
   endtask

   // One clock cycle. It checks in_ready combinationally against the model,
   // advances the model across the edge, and then checks the registered outputs.
   task automatic cyc();
      int   g [2];
      logic x [2];
      #1;
      for (int d = 0; d < 2; d++) begin
         int n = (d == 0) ? 4 : 3;
         g[d] = model_grant(n, m_ptr[d]);
         x[d] = (!m_vld[d] || out_ready) && g[d] >= 0 && !rst;
      end
      chk("in_ready4", {28'd0, in_ready4}, x[0] ? (32'd1 << g[0]) : 32'd0);
      chk("in_ready3", {29'd0, in_ready3}, x[1] ? (32'd1 << g[1]) : 32'd0);
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
         int n = (d == 0) ? 4 : 3;
         if (rst) begin
            m_vld[d] = 1'b0; m_dat[d] = '0; m_chn[d] = 0; m_ptr[d] = 0;
         end else if (x[d]) begin
            m_vld[d] = 1'b1;
            m_dat[d] = in_data[g[d]*16 +: 16];
            m_chn[d] = g[d];
            m_ptr[d] = (g[d] + 1) % n;
         end else if (m_vld[d] && out_ready) begin
            m_vld[d] = 1'b0;
         end
      end
      #1;
      chk("out_valid4", {31'd0, out_valid4}, {31'd0, m_vld[0]});
      chk("out_data4",  {16'd0, out_data4},  {16'd0, m_dat[0]});
      chk("out_chan4",  {30'd0, out_chan4},  m_chn[0]);
      chk("out_valid3", {31'd0, out_valid3}, {31'd0, m_vld[1]});
      chk("out_data3",  {16'd0, out_data3},  {16'd0, m_dat[1]});
      chk("out_chan3",  {30'd0, out_chan3},  m_chn[1]);
   endtask

   initial begin
      int exp4 [6];
      int exp3 [6];
      int seq4 [4];
      exp4 = '{0, 1, 2, 3, 0, 1};
      exp3 = '{0, 1, 2, 0, 1, 2};
      seq4 = '{1, 3, 1, 3};
      for (int d = 0; d < 2; d++) begin
         m_vld[d] = 1'b0; m_dat[d] = '0; m_chn[d] = 0; m_ptr[d] = 0;
      end
      rst = 1'b1; in_data = '0; in_valid = '0; mode = 1'b0; sel = '0; out_ready = 1'b0;

      // Reset state.
      cyc(); cyc();
      chk("reset_valid", {31'd0, out_valid4}, 32'd0);
      chk("reset_data", {16'd0, out_data4}, 32'd0);
      rst = 1'b0;

      // Fixed select: channel 2 only.
      for (int i = 0; i < 4; i++) set_word(i, 16'h1000 + 16'(i));
      set_word(2, 16'h1234);
      mode = 1'b0; sel = 2'd2; in_valid = 4'hF; out_ready = 1'b1;
      #1 chk("fix_rdy", {28'd0, in_ready4}, 32'h4);
      cyc();
      chk("fix_data", {16'd0, out_data4}, 32'h1234);
      chk("fix_chan", {30'd0, out_chan4}, 32'd2);
      in_valid = 4'b1011;
      #1 chk("fix_norrdy", {28'd0, in_ready4}, 32'd0);
      cyc();
      chk("fix_drop", {31'd0, out_valid4}, 32'd0);

      // Mid-stream reset discards BEEF.
      set_word(0, 16'hBEEF); sel = 2'd0; in_valid = 4'hF;
      cyc();
      chk("beef", {16'd0, out_data4}, 32'hBEEF);
      rst = 1'b1; out_ready = 1'b0;
      cyc();
      chk("rst_mid_vld", {31'd0, out_valid4}, 32'd0);
      chk("rst_mid_dat", {16'd0, out_data4}, 32'd0);
      chk("rst_mid_chn", {30'd0, out_chan4}, 32'd0);
      rst = 1'b0; out_ready = 1'b1; mode = 1'b1;

      // Round-robin wrap from ptr 0 in both builds.
      for (int c = 0; c < 6; c++) begin
         cyc();
         chk("rr4_chan", {30'd0, out_chan4}, exp4[c]);
         chk("rr3_chan", {30'd0, out_chan3}, exp3[c]);
         chk("rr4_vld", {31'd0, out_valid4}, 32'd1);
      end

      // Sparse round-robin after a fresh reset: channels 1 and 3 only.
      rst = 1'b1; cyc(); rst = 1'b0;
      in_valid = 4'b1010;
      for (int c = 0; c < 4; c++) begin
         cyc();
         chk("rr_sparse", {30'd0, out_chan4}, seq4[c]);
      end

      // Back-pressure: a word is held and out_ready is low for 3 cycles.
      in_valid = 4'hF; out_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1 chk("bp_rdy", {28'd0, in_ready4}, 32'd0);
         cyc();
         chk("bp_chan", {30'd0, out_chan4}, 32'd3);
      end
      out_ready = 1'b1;
      cyc();
      chk("bp_reload_vld", {31'd0, out_valid4}, 32'd1);
      chk("bp_reload_chn", {30'd0, out_chan4}, 32'd0);

      // The 3-channel build never grants sel = 3.
      mode = 1'b0; sel = 2'd3;
      #1 chk("np2_rdy", {29'd0, in_ready3}, 32'd0);
      cyc(); cyc();
      chk("np2_vld", {31'd0, out_valid3}, 32'd0);

      // Mode switch while ptr = 2 and a word is held.
      rst = 1'b1; cyc(); rst = 1'b0;
      mode = 1'b1; cyc(); cyc();
      out_ready = 1'b0; mode = 1'b0; sel = 2'd0;
      cyc();
      chk("msw_hold", {30'd0, out_chan4}, 32'd1);
      out_ready = 1'b1;
      cyc();
      chk("msw_next", {30'd0, out_chan4}, 32'd0);

      // Randomized traffic.
      for (int c = 0; c < 400; c++) begin
         rst       = ($urandom_range(0, 39) == 0);
         in_valid  = 4'($urandom);
         in_data   = {$urandom, $urandom};
         mode      = 1'($urandom);
         sel       = 2'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         cyc();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
